// File: rtl/ysyx_25040129_lsu_pkg.sv
// LSU shared definitions: register/CSR index widths, funct3 load/store
// encodings, AXI response codes and the LSU FSM state encoding.
`ifndef ysyx_25040129_REGS_DIG
`define ysyx_25040129_REGS_DIG 5
`endif
`ifndef ysyx_25040129_CSR_DIG
`define ysyx_25040129_CSR_DIG 12
`endif

package ysyx_25040129_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_DONE
    } lsu_state_e;
endpackage

// File: rtl/ysyx_25040129_lsu_align.sv
// Combinational byte-lane alignment: load extract (shift + sign/zero extend)
// and store wdata/wstrb generation from the low address bits.
import ysyx_25040129_lsu_pkg::*;

module ysyx_25040129_lsu_align (
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    output logic [31:0] ldata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb
);
    logic [31:0] shifted;
    logic [3:0]  strb_base;

    assign shifted = rdata >> {off, 3'b000};
    assign wdata   = sdata << {off, 3'b000};
    // 4-bit shift truncates strobes that would fall off the word
    assign wstrb   = strb_base << off;

    // load extract by access size/signedness; W uses the raw word
    always_comb begin
        ldata = rdata;
        unique case (funct3)
            F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ldata = {24'b0, shifted[7:0]};
            F3_HU:   ldata = {16'b0, shifted[15:0]};
            default: ldata = rdata;
        endcase
    end

    // store strobe pattern before positioning
    always_comb begin
        strb_base = 4'b1111;
        case (funct3[1:0])
            2'b00:   strb_base = 4'b0001;
            2'b01:   strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end
endmodule

// File: rtl/ysyx_25040129_lsu.sv
// Load/store unit between EXU and WBU with an AXI4-Lite master port.
// Optional YSYX_25040129_DEBUG_EN adds pc/inst passthrough and device flag.
import ysyx_25040129_lsu_pkg::*;

module ysyx_25040129_lsu #(
    parameter logic [31:0] DEV_BASE = 32'hA000_0000,
    parameter logic [31:0] DEV_MASK = 32'hF000_0000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                is_req_valid_from_exu,
    output logic                                is_req_ready_to_exu,
    input  logic [31:0]                         alu_result_in_lsu,
    input  logic [31:0]                         store_data_in_lsu,
    input  logic                                mem_read_in_lsu,
    input  logic                                mem_write_in_lsu,
    input  logic [2:0]                          funct3_in_lsu,
    input  logic [`ysyx_25040129_REGS_DIG-1:0]  rd_in_lsu,
    input  logic [`ysyx_25040129_CSR_DIG-1:0]   csr_addr_in_lsu,
    input  logic                                csr_write_in_lsu,
    input  logic                                reg_write_in_lsu,
    input  logic                                ebreak_in_lsu,
    output logic [31:0]                         araddr,
    output logic                                arvalid,
    input  logic                                arready,
    input  logic [31:0]                         rdata,
    input  logic [1:0]                          rresp,
    input  logic                                rvalid,
    output logic                                rready,
    output logic [31:0]                         awaddr,
    output logic                                awvalid,
    input  logic                                awready,
    output logic [31:0]                         wdata,
    output logic [3:0]                          wstrb,
    output logic                                wvalid,
    input  logic                                wready,
    input  logic [1:0]                          bresp,
    input  logic                                bvalid,
    output logic                                bready,
    output logic                                is_req_valid_to_wbu,
    input  logic                                is_req_ready_from_wbu,
    output logic [`ysyx_25040129_REGS_DIG-1:0]  rd_out_lsu,
    output logic [31:0]                         result_out_lsu,
    output logic [`ysyx_25040129_CSR_DIG-1:0]   csr_addr_out_lsu,
    output logic                                csr_write_out_lsu,
    output logic                                reg_write_out_lsu,
    output logic                                ebreak_out_lsu,
    output logic                                lsu_access_fault,
    output logic                                is_data_forward_valid_from_lsu,
    output logic [31:0]                         lsu_forward_data
`ifdef YSYX_25040129_DEBUG_EN
    ,
    input  logic [31:0]                         pc_in_lsu,
    input  logic [31:0]                         inst_in_lsu,
    output logic [31:0]                         pc_out_lsu,
    output logic [31:0]                         inst_out_lsu,
    output logic                                is_device_out_lsu
`endif
);
    lsu_state_e  state, next_state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [1:0]  al_off;
    logic [2:0]  al_f3;
    logic [31:0] al_ldata, al_wdata;
    logic [3:0]  al_wstrb;
    logic        accept;

    assign accept                         = (state == S_IDLE) && is_req_valid_from_exu;
    assign is_req_ready_to_exu            = (state == S_IDLE);
    assign is_req_valid_to_wbu            = (state == S_DONE);
    assign is_data_forward_valid_from_lsu = is_req_valid_to_wbu && reg_write_out_lsu;
    assign lsu_forward_data               = result_out_lsu;

    // store alignment needs live inputs at accept; load extract uses latched offset/size
    assign al_off = (state == S_IDLE) ? alu_result_in_lsu[1:0] : off_q;
    assign al_f3  = (state == S_IDLE) ? funct3_in_lsu : f3_q;

    ysyx_25040129_lsu_align u_align (
        .off    (al_off),
        .funct3 (al_f3),
        .rdata  (rdata),
        .sdata  (store_data_in_lsu),
        .ldata  (al_ldata),
        .wdata  (al_wdata),
        .wstrb  (al_wstrb)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // next-state: store wins when both mem_read and mem_write are set
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (is_req_valid_from_exu) begin
                if (mem_write_in_lsu)     next_state = S_WR;
                else if (mem_read_in_lsu) next_state = S_AR;
                else                      next_state = S_DONE;
            end
            S_AR:   if (arready) next_state = S_R;
            S_R:    if (rvalid)  next_state = S_DONE;
            // each of AW/W is done once its valid has dropped or handshakes now
            S_WR:   if ((!awvalid || awready) && (!wvalid || wready)) next_state = S_B;
            S_B:    if (bvalid)  next_state = S_DONE;
            S_DONE: if (is_req_ready_from_wbu) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // registered bundle and AXI outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            araddr <= '0; arvalid <= 1'b0; rready <= 1'b0;
            awaddr <= '0; awvalid <= 1'b0; wdata <= '0; wstrb <= '0; wvalid <= 1'b0;
            bready <= 1'b0;
            rd_out_lsu <= '0; result_out_lsu <= '0; csr_addr_out_lsu <= '0;
            csr_write_out_lsu <= 1'b0; reg_write_out_lsu <= 1'b0; ebreak_out_lsu <= 1'b0;
            lsu_access_fault <= 1'b0; off_q <= '0; f3_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    rd_out_lsu        <= rd_in_lsu;
                    result_out_lsu    <= alu_result_in_lsu;
                    csr_addr_out_lsu  <= csr_addr_in_lsu;
                    csr_write_out_lsu <= csr_write_in_lsu;
                    reg_write_out_lsu <= reg_write_in_lsu && !mem_write_in_lsu;
                    ebreak_out_lsu    <= ebreak_in_lsu;
                    lsu_access_fault  <= 1'b0;
                    off_q             <= alu_result_in_lsu[1:0];
                    f3_q              <= funct3_in_lsu;
                    if (mem_write_in_lsu) begin
                        awaddr  <= alu_result_in_lsu;
                        wdata   <= al_wdata;
                        wstrb   <= al_wstrb;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end else if (mem_read_in_lsu) begin
                        araddr  <= alu_result_in_lsu;
                        arvalid <= 1'b1;
                    end
                end
                S_AR: if (arready) begin
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                end
                S_R: if (rvalid) begin
                    rready           <= 1'b0;
                    result_out_lsu   <= al_ldata;
                    lsu_access_fault <= (rresp != RESP_OKAY);
                end
                S_WR: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) bready <= 1'b1;
                end
                S_B: if (bvalid) begin
                    bready           <= 1'b0;
                    lsu_access_fault <= (bresp != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

`ifdef YSYX_25040129_DEBUG_EN
    // debug trace registers captured with the bundle
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_out_lsu <= '0; inst_out_lsu <= '0; is_device_out_lsu <= 1'b0;
        end else if (accept) begin
            pc_out_lsu        <= pc_in_lsu;
            inst_out_lsu      <= inst_in_lsu;
            is_device_out_lsu <= (mem_read_in_lsu || mem_write_in_lsu) &&
                                 ((alu_result_in_lsu & DEV_MASK) == DEV_BASE);
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_25040129_lsu.sv
// Directed bench for the LSU: pass-through, loads, stores, faults, backpressure, reset.
`ifndef ysyx_25040129_REGS_DIG
`define ysyx_25040129_REGS_DIG 5
`endif
`ifndef ysyx_25040129_CSR_DIG
`define ysyx_25040129_CSR_DIG 12
`endif

module tb_ysyx_25040129_lsu;
    logic        clock = 1'b0, reset = 1'b1;
    logic        is_req_valid_from_exu = 0, is_req_ready_to_exu;
    logic [31:0] alu_result_in_lsu = 0, store_data_in_lsu = 0;
    logic        mem_read_in_lsu = 0, mem_write_in_lsu = 0;
    logic [2:0]  funct3_in_lsu = 0;
    logic [`ysyx_25040129_REGS_DIG-1:0] rd_in_lsu = 0, rd_out_lsu;
    logic [`ysyx_25040129_CSR_DIG-1:0]  csr_addr_in_lsu = 0, csr_addr_out_lsu;
    logic        csr_write_in_lsu = 0, reg_write_in_lsu = 0, ebreak_in_lsu = 0;
    logic [31:0] araddr, rdata = 0, awaddr, wdata;
    logic        arvalid, arready = 0, rvalid = 0, rready;
    logic [1:0]  rresp = 0, bresp = 0;
    logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
    logic [3:0]  wstrb;
    logic        is_req_valid_to_wbu, is_req_ready_from_wbu = 1;
    logic [31:0] result_out_lsu, lsu_forward_data;
    logic        csr_write_out_lsu, reg_write_out_lsu, ebreak_out_lsu;
    logic        lsu_access_fault, is_data_forward_valid_from_lsu;
`ifdef YSYX_25040129_DEBUG_EN
    logic [31:0] pc_in_lsu = 0, inst_in_lsu = 0, pc_out_lsu, inst_out_lsu;
    logic        is_device_out_lsu;
`endif

    int checks = 0, errors = 0;
    int aw_cnt = 0, w_cnt = 0;

    ysyx_25040129_lsu dut (
        .clock(clock), .reset(reset),
        .is_req_valid_from_exu(is_req_valid_from_exu), .is_req_ready_to_exu(is_req_ready_to_exu),
        .alu_result_in_lsu(alu_result_in_lsu), .store_data_in_lsu(store_data_in_lsu),
        .mem_read_in_lsu(mem_read_in_lsu), .mem_write_in_lsu(mem_write_in_lsu),
        .funct3_in_lsu(funct3_in_lsu), .rd_in_lsu(rd_in_lsu), .csr_addr_in_lsu(csr_addr_in_lsu),
        .csr_write_in_lsu(csr_write_in_lsu), .reg_write_in_lsu(reg_write_in_lsu),
        .ebreak_in_lsu(ebreak_in_lsu),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .is_req_valid_to_wbu(is_req_valid_to_wbu), .is_req_ready_from_wbu(is_req_ready_from_wbu),
        .rd_out_lsu(rd_out_lsu), .result_out_lsu(result_out_lsu),
        .csr_addr_out_lsu(csr_addr_out_lsu), .csr_write_out_lsu(csr_write_out_lsu),
        .reg_write_out_lsu(reg_write_out_lsu), .ebreak_out_lsu(ebreak_out_lsu),
        .lsu_access_fault(lsu_access_fault),
        .is_data_forward_valid_from_lsu(is_data_forward_valid_from_lsu),
        .lsu_forward_data(lsu_forward_data)
`ifdef YSYX_25040129_DEBUG_EN
        , .pc_in_lsu(pc_in_lsu), .inst_in_lsu(inst_in_lsu),
        .pc_out_lsu(pc_out_lsu), .inst_out_lsu(inst_out_lsu),
        .is_device_out_lsu(is_device_out_lsu)
`endif
    );

    always #5 clock = ~clock;

    // count completed AW / W handshakes
    always @(posedge clock) begin
        if (awvalid && awready) aw_cnt++;
        if (wvalid && wready)   w_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // present one bundle for a single accept edge
    task automatic issue(input logic [31:0] addr, input logic [31:0] sdata, input logic rd_op,
                         input logic wr_op, input logic [2:0] f3, input logic rw);
        is_req_valid_from_exu = 1;
        alu_result_in_lsu = addr; store_data_in_lsu = sdata;
        mem_read_in_lsu = rd_op; mem_write_in_lsu = wr_op;
        funct3_in_lsu = f3; reg_write_in_lsu = rw; rd_in_lsu = 5'd7;
        tick();
        is_req_valid_from_exu = 0;
        mem_read_in_lsu = 0; mem_write_in_lsu = 0;
    endtask

    // load with a given AR wait, then one-cycle R response
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] data, input logic [1:0] resp, input int ar_wait,
                           input logic [31:0] exp);
        issue(addr, 0, 1, 0, f3, 1);
        chk({tag, "_araddr"}, araddr, addr);
        for (int i = 0; i < ar_wait; i++) tick();
        chk({tag, "_arvalid_held"}, {31'b0, arvalid}, 1);
        arready = 1; tick(); arready = 0;
        chk({tag, "_rready"}, {31'b0, rready}, 1);
        rdata = data; rresp = resp; rvalid = 1; tick(); rvalid = 0; rresp = 0;
        chk({tag, "_valid"}, {31'b0, is_req_valid_to_wbu}, 1);
        chk({tag, "_result"}, result_out_lsu, exp);
    endtask

    initial begin
        logic [31:0] held;
        tick(); tick();
        chk("rst_valid_wbu", {31'b0, is_req_valid_to_wbu}, 0);
        chk("rst_arvalid", {31'b0, arvalid}, 0);
        chk("rst_awvalid", {31'b0, awvalid}, 0);
        chk("rst_result", result_out_lsu, 0);
        reset = 0;
        tick();
        chk("idle_ready_exu", {31'b0, is_req_ready_to_exu}, 1);

        // non-memory op: valid exactly one cycle after accept, no AXI traffic
        issue(32'h1234, 0, 0, 0, 3'b000, 1);
        chk("add_valid", {31'b0, is_req_valid_to_wbu}, 1);
        chk("add_result", result_out_lsu, 32'h1234);
        chk("add_fwd_valid", {31'b0, is_data_forward_valid_from_lsu}, 1);
        chk("add_fwd_data", lsu_forward_data, 32'h1234);
        chk("add_no_axi", {30'b0, arvalid, awvalid}, 0);
        tick();
        chk("add_back_idle", {30'b0, is_req_valid_to_wbu, is_req_ready_to_exu}, 1);

        // byte loads from offset 3: signed and unsigned
        do_load("lb", 32'h8000_0003, 3'b000, 32'h80FF_FF7F, 2'b00, 2, 32'hFFFF_FF80);
        tick();
        do_load("lbu", 32'h8000_0003, 3'b100, 32'h80FF_FF7F, 2'b00, 2, 32'h0000_0080);
        tick();
        do_load("lh2", 32'h8000_0002, 3'b001, 32'h8001_1234, 2'b00, 0, 32'hFFFF_8001);
        tick();

        // halfword store at offset 2 with awready lagging wready by 3 cycles
        aw_cnt = 0; w_cnt = 0;
        issue(32'h8000_0002, 32'h0000_BEEF, 0, 1, 3'b001, 1);
        chk("sh_awvalid", {31'b0, awvalid}, 1);
        chk("sh_wvalid", {31'b0, wvalid}, 1);
        chk("sh_wstrb", {28'b0, wstrb}, 32'hC);
        chk("sh_wdata", wdata, 32'hBEEF_0000);
        chk("sh_awaddr", awaddr, 32'h8000_0002);
        wready = 1; tick(); wready = 0;
        chk("sh_w_dropped", {30'b0, awvalid, wvalid}, 32'h2);
        tick(); tick();
        awready = 1; tick(); awready = 0;
        chk("sh_bready", {31'b0, bready}, 1);
        chk("sh_aw_cnt", aw_cnt, 1);
        chk("sh_w_cnt", w_cnt, 1);
        bvalid = 1; tick(); bvalid = 0;
        chk("sh_valid", {31'b0, is_req_valid_to_wbu}, 1);
        chk("sh_reg_write", {31'b0, reg_write_out_lsu}, 0);
        chk("sh_fault", {31'b0, lsu_access_fault}, 0);
        tick();

        // load with error response, WBU stalls for 4 cycles
        is_req_ready_from_wbu = 0;
        do_load("lw_err", 32'h8000_0004, 3'b010, 32'hDEAD_BEEF, 2'b10, 0, 32'hDEAD_BEEF);
        chk("lw_fault", {31'b0, lsu_access_fault}, 1);
        held = result_out_lsu;
        issue(32'h5555_0000, 0, 0, 0, 3'b000, 1);
        is_req_valid_from_exu = 1;
        for (int i = 0; i < 3; i++) tick();
        chk("stall_result", result_out_lsu, held);
        chk("stall_valid", {31'b0, is_req_valid_to_wbu}, 1);
        chk("stall_fault", {31'b0, lsu_access_fault}, 1);
        chk("stall_ready_exu", {31'b0, is_req_ready_to_exu}, 0);
        is_req_ready_from_wbu = 1; tick();
        is_req_valid_from_exu = 0;
        chk("stall_release", {31'b0, is_req_valid_to_wbu}, 0);
        tick();

        // reset while waiting in R with a response pending
        issue(32'h8000_0010, 0, 1, 0, 3'b010, 1);
        arready = 1; tick(); arready = 0;
        rvalid = 1; rdata = 32'h1111_2222;
        reset = 1; tick(); reset = 0;
        chk("rst_mid_rready", {31'b0, rready}, 0);
        chk("rst_mid_valid", {31'b0, is_req_valid_to_wbu}, 0);
        chk("rst_mid_result", result_out_lsu, 0);
        chk("rst_mid_araddr", araddr, 0);
        chk("rst_mid_rd", {27'b0, rd_out_lsu}, 0);
        tick(); rvalid = 0; tick();
        chk("late_rvalid", {31'b0, is_req_valid_to_wbu}, 0);

`ifdef YSYX_25040129_DEBUG_EN
        awready = 1; wready = 1;
        issue(32'hA000_03F8, 32'h1, 0, 1, 3'b010, 0);
        tick(); bvalid = 1; tick(); bvalid = 0;
        chk("dev_store", {31'b0, is_device_out_lsu}, 1);
        tick();
        issue(32'h8000_0000, 32'h1, 0, 1, 3'b010, 0);
        tick(); bvalid = 1; tick(); bvalid = 0;
        chk("mem_store", {31'b0, is_device_out_lsu}, 0);
        awready = 0; wready = 0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
